// File: rtl/spi_pixel_bridge_pkg.sv
// Shared defaults for the SPI pixel bridge: pixel width, FIFO depths and the
// bit-counter width helper.
package spi_pixel_bridge_pkg;

    localparam int PIXEL_WIDTH_DEFAULT = 8;
    localparam int RX_DEPTH_DEFAULT    = 4;
    localparam int TX_DEPTH_DEFAULT    = 4;

    // The bit counter must be able to hold the value pixel_width itself.
    function automatic int bit_cnt_width(input int pixel_width);
        return $clog2(pixel_width + 1);
    endfunction

endpackage

// File: rtl/spi_pixel_bridge_pixel_fifo.sv
// pixel_fifo: small synchronous FIFO with registered count. It accepts a push
// and a pop together even when full. A pop while empty is ignored, so a push
// in that cycle is not bypassed to the reader.
module pixel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       nreset_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
        mem_d   = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Storage is reset so the head reads zero out of reset.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/spi_pixel_bridge.sv
// SPI-slave (mode 0) pixel bridge: deframes SDI words into an RX FIFO for the
// core and shifts core results from a TX FIFO out on SDO. Sticky error flags
// exist only when SPI_ERR_FLAGS_EN is defined.
module spi_pixel_bridge
    import spi_pixel_bridge_pkg::*;
#(
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEFAULT,
    parameter int RX_DEPTH    = RX_DEPTH_DEFAULT,
    parameter int TX_DEPTH    = TX_DEPTH_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   nreset_i,
    input  logic                   spi_sck_i,
    input  logic                   spi_cs_i,
    input  logic                   spi_sdi_i,
    output logic                   spi_sdo_o,
    output logic [PIXEL_WIDTH-1:0] in_px_o,
    output logic                   in_valid_o,
    input  logic                   in_ready_i,
    input  logic [PIXEL_WIDTH-1:0] out_px_i,
    input  logic                   out_valid_i,
    output logic                   out_ready_o,
    output logic                   rx_overflow_o,
    output logic                   tx_underflow_o
);

    localparam int CNT_W    = bit_cnt_width(PIXEL_WIDTH);
    localparam int RX_CNT_W = $clog2(RX_DEPTH + 1);
    localparam int TX_CNT_W = $clog2(TX_DEPTH + 1);

    logic [1:0]             sck_sync_q, sck_sync_d;
    logic [1:0]             cs_sync_q, cs_sync_d;
    logic [1:0]             sdi_sync_q, sdi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [PIXEL_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [PIXEL_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                   tx_hold_q, tx_hold_d;

    logic                   sck_rise, sck_fall, cs_fall, cs_rise;
    logic [CNT_W-1:0]       cnt_inc;
    logic [PIXEL_WIDTH-1:0] rx_word;
    logic                   rx_push, rx_pop, rx_full, rx_empty;
    logic                   tx_load, tx_push, tx_full, tx_empty;
    logic [PIXEL_WIDTH-1:0] tx_head;
    logic [RX_CNT_W-1:0]    rx_count;
    logic [TX_CNT_W-1:0]    tx_count;

    always_comb begin
        sck_sync_d = {sck_sync_q[0], spi_sck_i};
        cs_sync_d  = {cs_sync_q[0], spi_cs_i};
        sdi_sync_d = {sdi_sync_q[0], spi_sdi_i};
        sck_prev_d = sck_sync_q[1];
        cs_prev_d  = cs_sync_q[1];

        sck_rise = sck_sync_q[1] & ~sck_prev_q & ~cs_sync_q[1];
        sck_fall = ~sck_sync_q[1] & sck_prev_q & ~cs_sync_q[1];
        cs_fall  = ~cs_sync_q[1] & cs_prev_q;
        cs_rise  = cs_sync_q[1] & ~cs_prev_q;

        cnt_inc    = bit_cnt_q + CNT_W'(1);
        rx_word    = {rx_shift_q[PIXEL_WIDTH-2:0], sdi_sync_q[1]};
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        tx_hold_d  = tx_hold_q;
        rx_push    = 1'b0;
        tx_load    = 1'b0;

        if (cs_fall) begin
            bit_cnt_d = '0;
            tx_load   = 1'b1;
            tx_hold_d = 1'b0;
        end else if (cs_rise) begin
            bit_cnt_d  = '0;
            rx_shift_d = '0;
            tx_hold_d  = 1'b0;
        end else if (sck_rise) begin
            rx_shift_d = rx_word;
            if (cnt_inc == CNT_W'(PIXEL_WIDTH)) begin
                bit_cnt_d = '0;
                rx_push   = 1'b1;
                tx_load   = 1'b1;
                tx_hold_d = 1'b1;
            end else begin
                bit_cnt_d = cnt_inc;
            end
        end else if (sck_fall) begin
            // A word loaded on the last rising edge already presents its MSB;
            // the trailing falling edge of that word must not shift it away.
            if (tx_hold_q) begin
                tx_hold_d = 1'b0;
            end else begin
                tx_shift_d = {tx_shift_q[PIXEL_WIDTH-2:0], 1'b0};
            end
        end

        if (tx_load) begin
            tx_shift_d = tx_empty ? '0 : tx_head;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            sck_sync_q <= 2'b00;
            cs_sync_q  <= 2'b11;
            sdi_sync_q <= 2'b00;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            tx_hold_q  <= 1'b0;
        end else begin
            sck_sync_q <= sck_sync_d;
            cs_sync_q  <= cs_sync_d;
            sdi_sync_q <= sdi_sync_d;
            sck_prev_q <= sck_prev_d;
            cs_prev_q  <= cs_prev_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            tx_hold_q  <= tx_hold_d;
        end
    end

    assign rx_pop  = ~rx_empty & in_ready_i;
    assign tx_push = out_valid_i & ~tx_full;

    pixel_fifo #(
        .WIDTH(PIXEL_WIDTH),
        .DEPTH(RX_DEPTH)
    ) u_rx_fifo (
        .clk_i      (clk_i),
        .nreset_i   (nreset_i),
        .push_i     (rx_push),
        .push_data_i(rx_word),
        .pop_i      (rx_pop),
        .head_o     (in_px_o),
        .full_o     (rx_full),
        .empty_o    (rx_empty),
        .count_o    (rx_count)
    );

    pixel_fifo #(
        .WIDTH(PIXEL_WIDTH),
        .DEPTH(TX_DEPTH)
    ) u_tx_fifo (
        .clk_i      (clk_i),
        .nreset_i   (nreset_i),
        .push_i     (tx_push),
        .push_data_i(out_px_i),
        .pop_i      (tx_load),
        .head_o     (tx_head),
        .full_o     (tx_full),
        .empty_o    (tx_empty),
        .count_o    (tx_count)
    );

    assign spi_sdo_o   = tx_shift_q[PIXEL_WIDTH-1];
    assign in_valid_o  = ~rx_empty;
    assign out_ready_o = ~tx_full;

    logic unused_counts;
    assign unused_counts = ^{rx_count, tx_count};

`ifdef SPI_ERR_FLAGS_EN
    logic rx_overflow_q, rx_overflow_d;
    logic tx_underflow_q, tx_underflow_d;

    always_comb begin
        rx_overflow_d  = rx_overflow_q | (rx_push & rx_full & ~rx_pop);
        tx_underflow_d = tx_underflow_q | (tx_load & tx_empty);
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            rx_overflow_q  <= 1'b0;
            tx_underflow_q <= 1'b0;
        end else begin
            rx_overflow_q  <= rx_overflow_d;
            tx_underflow_q <= tx_underflow_d;
        end
    end

    assign rx_overflow_o  = rx_overflow_q;
    assign tx_underflow_o = tx_underflow_q;
`else
    logic unused_flag_sources;
    assign unused_flag_sources = rx_full;
    assign rx_overflow_o  = 1'b0;
    assign tx_underflow_o = 1'b0;
`endif

endmodule
